// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared widths, lane types and FSM states for the sort byte streamer
package sort_pkg;

    localparam int BYTE_W  = 8;
    localparam int N_BYTES = 8;
    localparam int FRAME_W = 64;

    typedef logic [0:BYTE_W-1]  byte_t;
    typedef logic [0:FRAME_W-1] frame_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/sort_byte_streamer.sv
// rtl/sort_byte_streamer.sv - packs 8 ingress bytes into a frame, hands it to an external sorter, streams the result back out
module sort_byte_streamer
    import sort_pkg::*;
#(
    parameter int TIMEOUT_CYC = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [0:63] srt_in,
    output logic        srt_valid_in,
    input  logic [0:63] srt_out,
    input  logic        srt_valid_out,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    localparam logic [7:0] TIMEOUT_Q = 8'(TIMEOUT_CYC);
    localparam logic [2:0] LAST_IDX  = 3'(N_BYTES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] wait_q, wait_d;
    frame_t     asm_q, asm_d;
    frame_t     srt_q, srt_d;
    frame_t     cap_q, cap_d;
    logic       prev_q;
    logic       err_q, err_d;
    logic       err_set;
    logic       rise;
    byte_t      egress_byte;

    assign rise = srt_valid_out && !prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        asm_d   = asm_q;
        srt_d   = srt_q;
        cap_d   = cap_q;
        err_set = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (s_valid) begin
                    asm_d[{cnt_q, 3'b000} +: BYTE_W] = s_data;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LAST_IDX) begin
                        // srt_in is a separate register so it stays put while the next frame assembles
                        srt_d   = asm_d;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wait_d  = 8'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wait_d = wait_q + 8'd1;
                if (rise) begin
                    cap_d   = srt_out;
                    idx_d   = 3'd0;
                    state_d = ST_DRAIN;
                end else if (wait_d == TIMEOUT_Q) begin
                    err_set = 1'b1;
                    cnt_d   = 3'd0;
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase

        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_FILL;
            cnt_q   <= 3'd0;
            idx_q   <= 3'd0;
            wait_q  <= 8'd0;
            asm_q   <= '0;
            srt_q   <= '0;
            cap_q   <= '0;
            prev_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            asm_q   <= asm_d;
            srt_q   <= srt_d;
            cap_q   <= cap_d;
            prev_q  <= srt_valid_out;
            err_q   <= err_d;
        end
    end

    // Outputs are gated by rst so they read zero for the whole reset window, not just after the first edge
    assign egress_byte  = cap_q[{idx_q, 3'b000} +: BYTE_W];
    assign s_ready      = rst && (state_q == ST_FILL);
    assign srt_valid_in = rst && (state_q == ST_ISSUE);
    assign m_valid      = rst && (state_q == ST_DRAIN);
    assign m_data       = m_valid ? egress_byte : 8'd0;
    assign srt_in       = rst ? srt_q : '0;
    assign busy         = rst && ((state_q != ST_FILL) || (cnt_q != 3'd0));
    assign timeout_err  = rst && err_q;

endmodule

// File: tb/tb_sort_byte_streamer.sv
// tb/tb_sort_byte_streamer.sv - randomized and directed self-checking bench for sort_byte_streamer
module tb_sort_byte_streamer;

    localparam int TO = 31;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [0:63] srt_in;
    logic        srt_valid_in;
    logic [0:63] srt_out;
    logic        srt_valid_out;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  frame_b [8];
    int          sort_dly;
    int          cd = 0;
    logic [0:63] pend;

    sort_byte_streamer #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .srt_in(srt_in), .srt_valid_in(srt_valid_in),
        .srt_out(srt_out), .srt_valid_out(srt_valid_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [0:63] sort_frame(input logic [0:63] f);
        logic [7:0]  q[$];
        logic [0:63] r;
        for (int i = 0; i < 8; i++) q.push_back(f[8*i +: 8]);
        q.sort();
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = q[i];
        return r;
    endfunction

    // Sorter model: drops its level one cycle after the strobe, raises it sort_dly cycles after; sort_dly=0 never answers
    always @(negedge clk) begin
        if (!rst) begin
            cd = 0;
        end else if (srt_valid_in) begin
            pend = sort_frame(srt_in);
            if (sort_dly > 0) cd = sort_dly;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == sort_dly - 1) srt_valid_out = 1'b0;
            if (cd == 0) begin
                srt_out       = pend;
                srt_valid_out = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) frame_b[i] = 8'($urandom);
    endtask

    // Entered and left at a negedge with the DUT idle in FILL
    task automatic run_frame(input int gap_max, input int dly, input int rdy_mode, input int rst_after);
        logic [0:63] ef;
        logic [7:0]  exp_q[$];
        int          idx;
        int          guard;
        bit          tog;

        ef = {frame_b[0], frame_b[1], frame_b[2], frame_b[3],
              frame_b[4], frame_b[5], frame_b[6], frame_b[7]};
        exp_q = {};
        for (int i = 0; i < 8; i++) exp_q.push_back(frame_b[i]);
        exp_q.sort();
        sort_dly = dly;

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                s_valid = 1'b0;
                @(negedge clk);
                chk("no_early_issue_gap", {63'd0, srt_valid_in}, 64'd0);
            end
            s_valid = 1'b1;
            s_data  = frame_b[i];
            chk("fill_s_ready", {63'd0, s_ready}, 64'd1);
            chk("no_early_issue", {63'd0, srt_valid_in}, 64'd0);
            if (i > 0) chk("fill_busy", {63'd0, busy}, 64'd1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("issue_strobe", {63'd0, srt_valid_in}, 64'd1);
        chk("issue_frame", srt_in, ef);
        chk("issue_s_ready", {63'd0, s_ready}, 64'd0);

        if (dly >= 2 && dly <= TO) begin
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                chk("wait_no_egress", {63'd0, m_valid}, 64'd0);
                chk("wait_s_ready", {63'd0, s_ready}, 64'd0);
                if (k == 1) chk("single_strobe", {63'd0, srt_valid_in}, 64'd0);
            end
            @(negedge clk);
            chk("frame_held", srt_in, ef);
            idx = 0;
            guard = 0;
            tog = 1'b1;
            while (idx < 8 && guard < 64) begin
                chk("drain_valid", {63'd0, m_valid}, 64'd1);
                chk("drain_data", {56'd0, m_data}, {56'd0, exp_q[idx]});
                chk("drain_s_ready", {63'd0, s_ready}, 64'd0);
                if (idx == rst_after) begin
                    rst = 1'b0;
                    m_ready = 1'b0;
                    @(negedge clk);
                    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
                    chk("rst_busy", {63'd0, busy}, 64'd0);
                    chk("rst_m_data", {56'd0, m_data}, 64'd0);
                    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
                    chk("post_rst_m_valid", {63'd0, m_valid}, 64'd0);
                    return;
                end
                case (rdy_mode)
                    0:       m_ready = 1'b1;
                    1:       begin m_ready = tog; tog = !tog; end
                    default: m_ready = 1'($urandom_range(0, 1));
                endcase
                if (m_ready) idx++;
                guard++;
                @(negedge clk);
            end
            m_ready = 1'b0;
            chk("drain_complete", 64'(idx), 64'd8);
            chk("post_drain_m_valid", {63'd0, m_valid}, 64'd0);
            chk("post_drain_s_ready", {63'd0, s_ready}, 64'd1);
            chk("post_drain_busy", {63'd0, busy}, 64'd0);
        end else begin
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                chk("to_wait_s_ready", {63'd0, s_ready}, 64'd0);
                chk("to_wait_err", {63'd0, timeout_err}, 64'd0);
            end
            @(negedge clk);
            chk("to_err_set", {63'd0, timeout_err}, 64'd1);
            chk("to_s_ready", {63'd0, s_ready}, 64'd1);
            chk("to_m_valid", {63'd0, m_valid}, 64'd0);
            chk("to_busy", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst           = 1'b0;
        s_data        = 8'd0;
        s_valid       = 1'b0;
        m_ready       = 1'b0;
        err_clr       = 1'b0;
        srt_out       = '0;
        srt_valid_out = 1'b1;
        sort_dly      = 8;

        repeat (3) @(negedge clk);
        chk("reset_s_ready", {63'd0, s_ready}, 64'd0);
        chk("reset_srt_in", srt_in, 64'd0);
        chk("reset_srt_valid_in", {63'd0, srt_valid_in}, 64'd0);
        chk("reset_m_data", {56'd0, m_data}, 64'd0);
        chk("reset_m_valid", {63'd0, m_valid}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_timeout_err", {63'd0, timeout_err}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("first_fill_s_ready", {63'd0, s_ready}, 64'd1);
        chk("first_fill_busy", {63'd0, busy}, 64'd0);

        // Nominal descending frame, with a stale-high sorter level left over from before reset
        for (int i = 0; i < 8; i++) frame_b[i] = 8'(8 - i);
        run_frame(0, 8, 0, -1);

        rand_frame();
        run_frame(0, 5, 1, -1);

        rand_frame();
        run_frame(3, 8, 0, -1);

        rand_frame();
        run_frame(0, 0, 0, -1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", {63'd0, timeout_err}, 64'd0);

        // Rise on the last WAIT cycle beats the timeout
        rand_frame();
        run_frame(0, TO, 0, -1);
        chk("edge_no_err", {63'd0, timeout_err}, 64'd0);

        // One cycle too late: timeout, with err_clr held to show set beats clear
        err_clr = 1'b1;
        rand_frame();
        run_frame(0, TO + 1, 0, -1);
        @(negedge clk);
        chk("err_clr_held", {63'd0, timeout_err}, 64'd0);
        err_clr = 1'b0;

        rand_frame();
        run_frame(1, 3, 2, -1);

        rand_frame();
        run_frame(0, 6, 0, 4);
        rand_frame();
        run_frame(0, 4, 0, -1);

        for (int f = 0; f < 6; f++) begin
            rand_frame();
            if (f == 2) for (int i = 0; i < 8; i++) frame_b[i] = 8'(i * 37 + 200);
            run_frame(2, $urandom_range(2, TO), 2, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sort_byte_streamer.md
SORT_BYTE_STREAMER -- requirements
Module: sort_byte_streamer

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 31, is the maximum WAIT cycles before abort; legal values are 8..255.
REQ-002 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 s_data  input  8  ingress byte.
REQ-005 s_valid  input  1  ingress byte valid.
REQ-006 s_ready  output  1  ingress ready.
REQ-007 srt_in  output  64 [0:63]  frame to sorter; byte k is at [8k:8k+7].
REQ-008 srt_valid_in  output  1  frame strobe to sorter.
REQ-009 srt_out  input  64 [0:63]  sorted frame from sorter.
REQ-010 srt_valid_out  input  1  sorter result valid; level signal, may stay high from the previous frame.
REQ-011 m_data  output  8  egress byte.
REQ-012 m_valid  output  1  egress valid.
REQ-013 m_ready  input  1  egress ready.
REQ-014 busy  output  1  high when state is not FILL or the byte count is nonzero.
REQ-015 timeout_err  output  1  sticky abort flag.
REQ-016 err_clr  input  1  clears timeout_err.

Function
REQ-017 FSM states SHALL be FILL, ISSUE, WAIT and DRAIN; the reset state is FILL.
REQ-018 FILL behaviour:
- s_ready=1.
- A byte is accepted on s_valid&&s_ready; the first byte accepted goes to byte 0, in arrival order.
- The 3-bit count wraps 7->0 on the 8th byte, and the next state is ISSUE.
REQ-019 ISSUE behaviour:
- s_ready=0.
- srt_valid_in=1 for exactly one cycle.
- Next state is WAIT.
REQ-020 srt_in SHALL hold the assembled frame, stable from ISSUE until the next ISSUE.
REQ-021 The block SHALL register srt_valid_out each cycle and define rise = srt_valid_out && !prev.
REQ-022 WAIT behaviour:
- The wait counter clears on entry and increments each cycle.
- On rise, srt_out is captured and the next state is DRAIN.
- A level-high srt_valid_out without a rise SHALL be ignored.
REQ-023 WAIT timeout: if the counter reaches TIMEOUT_CYC without a rise, timeout_err is set, the byte count clears, and the next state is FILL; a rise in the same cycle wins over the timeout.
REQ-024 DRAIN behaviour:
- m_valid=1 and m_data=captured byte[idx], with idx starting at 0.
- idx advances on m_valid&&m_ready.
- After byte 7 transfers, the next state is FILL and m_valid drops in the following cycle.
REQ-025 m_data and m_valid SHALL remain stable while m_valid&&!m_ready.
REQ-026 Ingress and egress are mutually exclusive: s_ready SHALL be 0 in ISSUE, WAIT and DRAIN.
REQ-027 Minimum frame latency is 8 fill cycles, 1 ISSUE cycle, the sorter delay, and 8 drain cycles.
REQ-028 timeout_err clears on err_clr; if set and clear occur in the same cycle, set wins.

Reset
REQ-029 While rst=0 the block SHALL drive s_ready=0, srt_in=0, srt_valid_in=0, m_data=0, m_valid=0, busy=0 and timeout_err=0, and clear all counters, prev and the capture register.
REQ-030 In the first cycle after rst rises, the state is FILL with s_ready=1.
REQ-031 Reset asserted mid-frame in any state SHALL discard partial ingress and egress data without emitting further bytes.

Structure
REQ-032 Package sort_pkg SHALL hold:
- BYTE_W=8, N_BYTES=8, FRAME_W=64.
- typedef byte_t [0:7] and frame_t [0:63].
- The state enum typedef.
REQ-033 The block SHALL be a single module with no sub-modules; byte-lane assembly and selection SHALL use indexed part-selects.

Verification
REQ-034 Directed scenario 1 (nominal): feed 08,07,...,01 back-to-back.
- srt_in=0x0807060504030201 with a single srt_valid_in pulse.
- The sorter model rises after 8 cycles.
- Egress 01..08 in 8 consecutive cycles.
REQ-035 Directed scenario 2 (egress backpressure): m_ready alternates 1,0 during DRAIN; all 8 bytes are emitted in order with no duplicates, and m_data is held while stalled.
REQ-036 Directed scenario 3 (ingress gaps): s_valid is low on cycles between bytes; ISSUE occurs only after the 8th accepted byte, and srt_in is correct.
REQ-037 Directed scenario 4 (timeout): the sorter never rises; after 31 WAIT cycles timeout_err=1, the state is FILL, and s_ready=1; err_clr pulse -> 0.
REQ-038 Directed scenario 5 (stale level): srt_valid_out is held 1 from the prior frame and falls 1 cycle after ISSUE; capture occurs only on the next rise.
REQ-039 Directed scenario 6 (mid-operation reset): rst=0 during DRAIN after byte 3.
- Next cycle: m_valid=0 and busy=0.
- The next frame egresses from byte 0.
